// File: rtl/state_reg_pkg.sv
// Shared definitions for the one-hot state register slice.
// Holds the default parameter constants, the request classification used
// by the next-state logic, and the binary index width helper.
package state_reg_pkg;

  localparam int DEF_N_STATES  = 5;
  localparam int DEF_RESET_IDX = 0;
  localparam int DEF_RECOVER   = 1;
  localparam int DEF_DWELL_W   = 8;

  // What kind of request the current cycle carries
  typedef enum logic [1:0] {
    REQ_HOLD    = 2'd0,
    REQ_FORCE   = 2'd1,
    REQ_LOAD    = 2'd2,
    REQ_ILLEGAL = 2'd3
  } req_kind_e;

  // Binary index width for n one-hot bits, never narrower than one bit
  function automatic int idxWidth(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot to binary encoder.
// Ports:
//   vec_i   - one-hot input vector
//   idx_o   - binary index of the set bit (OR of set-bit indices if not one-hot)
//   legal_o - high when exactly one bit of vec_i is set
module onehot_enc
  import state_reg_pkg::*;
#(
  parameter int N  = DEF_N_STATES,
  parameter int IW = idxWidth(N)
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          legal_o
);

  // OR together the indices of all set bits; exact when the input is one-hot
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        idx_o = idx_o | IW'(i);
      end
    end
  end

  // Non-zero and clearing the lowest set bit leaves nothing: exactly one bit
  assign legal_o = (vec_i != '0) && ((vec_i & (vec_i - N'(1))) == '0);

endmodule

// File: rtl/onehot_state_reg.sv
// One-hot state register with forced jumps, illegal-request handling,
// change pulse, saturating dwell counter and sticky error flag.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   en, nxt_state     - load request with the requested one-hot state
//   force_vld/_idx    - jump request by binary index, wins over en
//   err_clr           - clears the sticky error flag
//   state, state_idx  - current one-hot state and its binary index
//   changed           - one-cycle pulse after the state value changes
//   dwell             - cycles spent in the current state, saturating
//   err               - sticky illegal-request flag
module onehot_state_reg
  import state_reg_pkg::*;
#(
  parameter int N_STATES  = DEF_N_STATES,
  parameter int RESET_IDX = DEF_RESET_IDX,
  parameter int RECOVER   = DEF_RECOVER,
  parameter int DWELL_W   = DEF_DWELL_W,
  localparam int IW       = idxWidth(N_STATES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_STATES-1:0] nxt_state,
  input  logic                force_vld,
  input  logic [IW-1:0]       force_idx,
  input  logic                err_clr,
  output logic [N_STATES-1:0] state,
  output logic [IW-1:0]       state_idx,
  output logic                changed,
  output logic [DWELL_W-1:0]  dwell,
  output logic                err
);

  localparam logic [N_STATES-1:0] RESET_VEC = N_STATES'(1) << RESET_IDX;
  localparam logic [DWELL_W-1:0]  DWELL_MAX = {DWELL_W{1'b1}};

  logic [N_STATES-1:0] state_q, state_d;
  logic                changed_q, changed_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic                err_q, err_d;

  logic [IW-1:0]       nxtIdx;
  logic                nxtLegal;
  logic                stateLegal;
  logic                forceInRange;
  req_kind_e           reqKind;

  onehot_enc #(.N(N_STATES), .IW(IW)) u_nxt_enc (
    .vec_i   (nxt_state),
    .idx_o   (nxtIdx),
    .legal_o (nxtLegal)
  );

  onehot_enc #(.N(N_STATES), .IW(IW)) u_state_enc (
    .vec_i   (state_q),
    .idx_o   (state_idx),
    .legal_o (stateLegal)
  );

  assign forceInRange = int'(force_idx) < N_STATES;

  // Classify the request, then derive next state, change pulse, dwell and err
  always_comb begin
    reqKind = REQ_HOLD;
    if (force_vld) begin
      reqKind = forceInRange ? REQ_FORCE : REQ_ILLEGAL;
    end else if (en) begin
      reqKind = nxtLegal ? REQ_LOAD : REQ_ILLEGAL;
    end

    state_d = state_q;
    unique case (reqKind)
      REQ_FORCE:   state_d = N_STATES'(1) << force_idx;
      // Rebuild from the index so the loaded value is one-hot by construction
      REQ_LOAD:    state_d = N_STATES'(1) << nxtIdx;
      REQ_ILLEGAL: if (RECOVER != 0) state_d = RESET_VEC;
      default:     state_d = state_q;
    endcase
    // Self-heal should the register ever be upset out of one-hot
    if (!stateLegal) state_d = RESET_VEC;

    changed_d = (state_d != state_q);

    // Reloading the same state keeps counting
    if (changed_d) begin
      dwell_d = '0;
    end else if (dwell_q == DWELL_MAX) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + DWELL_W'(1);
    end

    // A new illegal request beats a clear on the same edge
    if (reqKind == REQ_ILLEGAL) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_VEC;
      changed_q <= 1'b0;
      dwell_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      changed_q <= changed_d;
      dwell_q   <= dwell_d;
      err_q     <= err_d;
    end
  end

  assign state   = state_q;
  assign changed = changed_q;
  assign dwell   = dwell_q;
  assign err     = err_q;

endmodule
